// File: rtl/uart_rx_core.sv
// 16x-oversampling UART receiver: start/data/stop framing, single-entry holding register, framing and overrun pulses.
// Latency: VALIDo rises 152 oversample ticks + 1 clock after start detect; holding register is held until READYi.
module uart_rx_core #(
   parameter int DATA_WIDTH = 32,
   parameter int DATA_BITS  = 8
) (
   input  logic                  CLKip,
   input  logic                  RSTNi,
   input  logic [DATA_WIDTH-1:0] DIVi,
   input  logic                  RXi,
   input  logic                  READYi,
   output logic [DATA_BITS-1:0]  DATAo,
   output logic                  VALIDo,
   output logic                  FERRo,
   output logic                  OVRo
);

   localparam int SW = $clog2(DATA_BITS + 1);
   localparam logic [SW-1:0] LAST_SAMPLE = SW'(DATA_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   state_t                state;
   state_t                state_nxt;

   logic                  rx_m;
   logic                  rx_s;
   logic [DATA_WIDTH-1:0] div_q;
   logic [DATA_WIDTH-1:0] tick_cnt;
   logic [3:0]            bit_tick;
   logic [SW-1:0]         samp_cnt;
   logic [DATA_BITS-1:0]  shift;

   logic                  tick;
   logic                  start_det;
   logic                  clr_bit;
   logic                  shift_en;
   logic                  frame_good;
   logic                  frame_bad;

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge CLKip) begin
      if (!RSTNi) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
      end else begin
         rx_m <= RXi;
         rx_s <= rx_m;
      end
   end

   assign tick = (state != IDLE) && (tick_cnt == div_q);

   always_ff @(posedge CLKip) begin
      if (!RSTNi) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      start_det  = 1'b0;
      clr_bit    = 1'b0;
      shift_en   = 1'b0;
      frame_good = 1'b0;
      frame_bad  = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               start_det = 1'b1;
               state_nxt = START;
            end
         end
         START: begin
            // Mid-start-bit check rejects glitches shorter than half a bit.
            if (tick && (bit_tick == 4'd7)) begin
               clr_bit   = 1'b1;
               state_nxt = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (tick && (bit_tick == 4'd15)) begin
               shift_en = 1'b1;
               if (samp_cnt == LAST_SAMPLE) begin
                  state_nxt = STOP;
               end
            end
         end
         STOP: begin
            if (tick && (bit_tick == 4'd15)) begin
               state_nxt  = IDLE;
               frame_good = rx_s;
               frame_bad  = !rx_s;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Divisor is latched per frame so a DIVi update cannot tear a frame in flight.
   always_ff @(posedge CLKip) begin
      if (!RSTNi) begin
         div_q    <= '0;
         tick_cnt <= '0;
         bit_tick <= '0;
         samp_cnt <= '0;
         shift    <= '0;
      end else if (start_det) begin
         div_q    <= DIVi;
         tick_cnt <= '0;
         bit_tick <= '0;
         samp_cnt <= '0;
      end else if (state != IDLE) begin
         tick_cnt <= tick ? '0 : tick_cnt + DATA_WIDTH'(1);
         if (clr_bit) begin
            bit_tick <= '0;
            samp_cnt <= '0;
         end else begin
            if (tick) begin
               bit_tick <= bit_tick + 4'd1;
            end
            if (shift_en) begin
               shift    <= {rx_s, shift[DATA_BITS-1:1]};
               samp_cnt <= samp_cnt + SW'(1);
            end
         end
      end
   end

   // Holding register: a consumer handshake in the same cycle frees it for the new byte.
   always_ff @(posedge CLKip) begin
      if (!RSTNi) begin
         DATAo  <= '0;
         VALIDo <= 1'b0;
         FERRo  <= 1'b0;
         OVRo   <= 1'b0;
      end else begin
         FERRo <= frame_bad;
         OVRo  <= 1'b0;
         if (frame_good) begin
            if (!VALIDo || READYi) begin
               DATAo  <= shift;
               VALIDo <= 1'b1;
            end else begin
               OVRo <= 1'b1;
            end
         end else if (VALIDo && READYi) begin
            VALIDo <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: frame-level model of expected output events, checked every cycle.
module tb_uart_rx_core;

   logic        clk = 1'b0;
   logic        rstn;
   logic        rx;
   logic        ready;
   logic [31:0] div;
   logic [7:0]  data;
   logic        valid;
   logic        ferr;
   logic        ovr;

   always #5 clk = ~clk;

   uart_rx_core #(.DATA_WIDTH(32), .DATA_BITS(8)) dut (
      .CLKip (clk),
      .RSTNi (rstn),
      .DIVi  (div),
      .RXi   (rx),
      .READYi(ready),
      .DATAo (data),
      .VALIDo(valid),
      .FERRo (ferr),
      .OVRo  (ovr)
   );

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   // One entry per frame end: the cycle the outcome appears and whether it is a framing error.
   typedef struct {
      int         at;
      bit         bad;
      logic [7:0] b;
   } ev_t;
   ev_t evq[$];

   bit         m_valid = 1'b0;
   bit         m_ferr  = 1'b0;
   bit         m_ovr   = 1'b0;
   logic [7:0] m_data  = 8'h00;
   bit         started = 1'b0;

   int         rise_cyc   = -1;
   int         ferr_cyc   = -1;
   int         ovr_cyc    = -1;
   logic [7:0] rise_data  = 8'h00;
   logic       prev_valid = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
      end
   endtask

   initial begin : compare
      bit  r;
      bit  rs;
      ev_t e;
      forever begin
         @(posedge clk);
         cyc++;
         r  = ready;
         rs = rstn;
         @(negedge clk);
         m_ferr = 1'b0;
         m_ovr  = 1'b0;
         if (!rs) begin
            started = 1'b1;
            m_valid = 1'b0;
            m_data  = 8'h00;
            evq.delete();
         end else if (started) begin
            if (evq.size() > 0 && evq[0].at == cyc) begin
               e = evq.pop_front();
               if (e.bad) begin
                  m_ferr = 1'b1;
                  if (m_valid && r) m_valid = 1'b0;
               end else if (!m_valid || r) begin
                  m_data  = e.b;
                  m_valid = 1'b1;
               end else begin
                  m_ovr = 1'b1;
               end
            end else if (m_valid && r) begin
               m_valid = 1'b0;
            end
         end
         if (started) begin
            chk("valid", {31'd0, valid}, {31'd0, m_valid});
            chk("data",  {24'd0, data},  {24'd0, m_data});
            chk("ferr",  {31'd0, ferr},  {31'd0, m_ferr});
            chk("ovr",   {31'd0, ovr},   {31'd0, m_ovr});
            if (valid === 1'b1 && prev_valid !== 1'b1) begin
               rise_cyc  = cyc;
               rise_data = data;
            end
            prev_valid = valid;
            if (ferr === 1'b1) ferr_cyc = cyc;
            if (ovr === 1'b1)  ovr_cyc  = cyc;
         end
      end
   end

   task automatic idle(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // 8N1 frame at 16*(d+1) clocks per bit; outcome due 2 sync flops + 1 detect + 152 ticks later.
   task automatic send(input logic [7:0] b, input bit stop, input int d, output int n);
      logic [9:0] fr;
      fr = {stop, b, 1'b0};
      n  = cyc;
      evq.push_back('{n + 3 + 152 * (d + 1), !stop, b});
      for (int j = 0; j < 10; j++) begin
         rx = fr[j];
         repeat (16 * (d + 1)) @(posedge clk);
         #1;
      end
      rx = 1'b1;
   endtask

   initial begin : stim
      int n1;
      int n2;
      rstn  = 1'b0;
      rx    = 1'b1;
      ready = 1'b1;
      div   = 32'd0;
      idle(3);
      rstn = 1'b1;
      idle(5);
      chk("rst_valid", {31'd0, valid}, 32'd0);
      chk("rst_data",  {24'd0, data},  32'd0);
      chk("rst_ferr",  {31'd0, ferr},  32'd0);
      chk("rst_ovr",   {31'd0, ovr},   32'd0);

      // 0xA5 at 16 clocks/bit
      send(8'hA5, 1'b1, 0, n1);
      idle(10);
      chk("a5_latency", rise_cyc - n1, 32'd155);
      chk("a5_data", {24'd0, rise_data}, 32'hA5);

      // divisor 3, back-to-back frames, DIVi disturbed mid-frame
      div = 32'd3;
      fork
         send(8'h3C, 1'b1, 3, n1);
         begin
            idle(300);
            div = 32'd7;
            idle(200);
            div = 32'd3;
         end
      join
      chk("3c_latency", rise_cyc - n1, 32'd611);
      chk("3c_data", {24'd0, rise_data}, 32'h3C);
      send(8'h81, 1'b1, 3, n2);
      chk("81_latency", rise_cyc - n2, 32'd611);
      chk("81_data", {24'd0, rise_data}, 32'h81);
      div = 32'd0;
      idle(20);

      // stop bit low
      send(8'h55, 1'b0, 0, n1);
      idle(40);
      chk("ferr_cycle", ferr_cyc - n1, 32'd155);

      // overrun with consumer stalled
      ready = 1'b0;
      send(8'h11, 1'b1, 0, n1);
      send(8'h22, 1'b1, 0, n2);
      idle(10);
      chk("ovr_cycle", ovr_cyc - n2, 32'd155);
      chk("ovr_hold_data", {24'd0, data}, 32'h11);
      chk("ovr_hold_valid", {31'd0, valid}, 32'd1);
      ready = 1'b1;
      idle(3);
      chk("drain_valid", {31'd0, valid}, 32'd0);

      // 4-clock glitch
      rx = 1'b0;
      idle(4);
      rx = 1'b1;
      idle(200);

      // reset during data bit 4 of 0xF0, then a clean 0x0F
      fork
         send(8'hF0, 1'b1, 0, n1);
         begin
            idle(88);
            rstn = 1'b0;
            idle(1);
            rstn = 1'b1;
         end
      join
      idle(20);
      send(8'h0F, 1'b1, 0, n2);
      idle(10);
      chk("after_rst_latency", rise_cyc - n2, 32'd155);
      chk("after_rst_data", {24'd0, rise_data}, 32'h0F);

      // break: two back-to-back framing errors, then line released
      n1 = cyc;
      rx = 1'b0;
      evq.push_back('{n1 + 155, 1'b1, 8'h00});
      evq.push_back('{n1 + 308, 1'b1, 8'h00});
      idle(308);
      rx = 1'b1;
      idle(60);
      chk("break_second_ferr", ferr_cyc - n1, 32'd308);
      chk("break_no_valid", {31'd0, valid}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
